alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered stage directly downstream of the 16-bit 74181-style ALU.
- Captures the ALU result with its destination register tag and derives condition flags.
- Buffers in a 2-entry skid buffer (main + skid) with valid/ready handshakes on both sides, presenting one result per cycle to register-file writeback.
- Commits architectural flags and counts committed writes.

Parameters:
- WIDTH, 16: data width of ALU result.
- RADDR, 4: destination register address width.
- CNTW, 16: width of commit counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  ALU result valid
- in_ready  output  1  stage can accept (registered)
- in_y  input  WIDTH  ALU result, bit 0 = LSB
- in_c  input  1  carry out from ALU carry logic
- in_v  input  1  signed overflow from ALU carry logic
- in_rd  input  RADDR  destination register
- in_we  input  1  result is written to register file
- in_setf  input  1  result updates architectural flags
- flush  input  1  discard all buffered results
- out_valid  output  1  writeback entry valid
- out_ready  input  1  writeback consumer accepts
- out_y  output  WIDTH  result to write
- out_rd  output  RADDR  destination register
- out_we  output  1  write enable qualifier
- flag_z, flag_n, flag_c, flag_v  output  1 each  architectural flags
- commit_cnt  output  CNTW  number of committed writes

Behaviour:
- Reset (async, immediate): out_valid=0, skid empty, in_ready=1, out_y/out_rd/out_we=0, all flags=0, commit_cnt=0. No transfer is recognised while rst is high.
- Input transfer: in_valid & in_ready at a rising edge.
- Output transfer: out_valid & out_ready at a rising edge.
- Per-entry captured fields: y, rd, we, setf, z=(in_y==0), n=in_y[WIDTH-1], c=in_c, v=in_v. Flags are computed at capture, not at output.
- Main register load:
  - Main loads when empty or an output transfer occurs.
  - Source priority: skid if valid, else input.
  - If main is full and out_ready=0, an accepted input goes to skid.
- in_ready is a register equal to !skid_valid_next. It never depends combinationally on out_ready.
- Latency: input transfer at edge N gives out_valid=1 after edge N (visible in cycle N+1). Sustained throughput is 1 per cycle with out_ready held high.
- Ordering: results leave strictly in arrival order. Skid content always precedes a new input.
- Stall: while out_valid=1 and out_ready=0, out_* hold stable.
- Full: main and skid both valid gives in_ready=0. in_valid is ignored.
- Flags update only on output transfer with setf=1, taking the entry's z/n/c/v. setf=0 leaves flags unchanged.
- commit_cnt increments by 1 on output transfer with we=1. It wraps from all-ones to 0.
- flush (synchronous, edge-sampled):
  - At the edge, main and skid are cleared and out_valid becomes 0.
  - in_ready becomes 1 next cycle.
  - Any input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still commits (flags/counter update).
- Simultaneous input and output transfer with skid empty: main is replaced by the input with no bubble.
- Simultaneous input and output transfer with skid full cannot occur, since in_ready=0.
- Reset mid-operation drops all entries and returns to reset values asynchronously.

Test Plan:
- Reset then single result: in_y=0x0000, in_rd=3, we=1, setf=1, c=1 accepted, out_ready=1. Required: out_valid next cycle with out_y=0, out_rd=3; after commit flag_z=1, flag_n=0, flag_c=1, flag_v=0, commit_cnt=1.
- Back-to-back stream 0x0001..0x0008, out_ready=1. Required: 8 outputs in order on consecutive cycles, in_ready stays 1, commit_cnt=8.
- Stall: send 0x8000, 0x1234, 0x5555 with out_ready=0. Required: first two accepted, in_ready=0 on the third until out_ready=1. Outputs come in order 0x8000, 0x1234, 0x5555. After 0x8000 commits with setf=1, flag_n=1.
- setf=0 entry y=0x0000 after a flag-setting entry y=0xFFFF. Required: flag_z stays 0 and flag_n stays 1.
- Flush with both entries full plus in_valid=1 and out_ready=1 in the same cycle. Required: only the main entry commits, skid and input are lost, out_valid=0, and in_ready=1 the following cycle.
- Wrap: force 65536 committed writes. Required: commit_cnt returns to 0x0000. Asserting rst mid-stall immediately clears out_valid and the flags.

Source files
------------

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result capture, 2-entry skid buffer, flag commit and write counter
//
// Purpose:
//   Registered stage behind the 16-bit ALU. Each accepted result is captured
//   together with its destination tag and its condition flags (z/n/c/v). The
//   flags are derived at capture time. Results pass through a main register
//   plus a skid register to register-file writeback, one per cycle. A result
//   that leaves with setf=1 updates the architectural flags. A result that
//   leaves with we=1 increments the commit counter.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready       upstream handshake (in_ready is registered)
//   in_y, in_c, in_v          ALU result, carry out, signed overflow
//   in_rd, in_we, in_setf     destination register, write qualifier, flag update
//   flush                     synchronous discard of all buffered results
//   out_valid / out_ready     writeback handshake
//   out_y, out_rd, out_we     writeback entry
//   flag_z/n/c/v              architectural flags
//   commit_cnt                number of committed writes (wraps)

module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int RADDR = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_c,
  input  logic             in_v,
  input  logic [RADDR-1:0] in_rd,
  input  logic             in_we,
  input  logic             in_setf,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [RADDR-1:0] out_rd,
  output logic             out_we,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic [CNTW-1:0]  commit_cnt
);

  // Entry layout: {y, rd, we, setf, z, n, c, v}
  localparam int EW = WIDTH + RADDR + 6;

  logic [EW-1:0]   r_main;
  logic [EW-1:0]   r_skid;
  logic            r_main_valid;
  logic            r_skid_valid;
  logic            r_in_ready;
  logic            r_flag_z;
  logic            r_flag_n;
  logic            r_flag_c;
  logic            r_flag_v;
  logic [CNTW-1:0] r_cnt;

  logic [EW-1:0]   w_in_entry;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_main_load;
  logic [EW-1:0]   w_main_n;
  logic [EW-1:0]   w_skid_n;
  logic            w_main_valid_n;
  logic            w_skid_valid_n;

  assign w_in_entry  = {in_y, in_rd, in_we, in_setf, (in_y == '0), in_y[WIDTH-1], in_c, in_v};
  assign w_in_xfer   = in_valid & r_in_ready;
  assign w_out_xfer  = r_main_valid & out_ready;
  assign w_main_load = !r_main_valid | w_out_xfer;

  // in_ready is registered as !skid_valid, so an accepted input always finds
  // the skid empty; a skid entry and a new input never compete for main.
  always_comb begin
    w_main_n       = r_main;
    w_skid_n       = r_skid;
    w_main_valid_n = r_main_valid;
    w_skid_valid_n = r_skid_valid;
    if (flush) begin
      w_main_n       = '0;
      w_main_valid_n = 1'b0;
      w_skid_valid_n = 1'b0;
    end else if (w_main_load) begin
      if (r_skid_valid) begin
        w_main_n       = r_skid;
        w_main_valid_n = 1'b1;
        w_skid_valid_n = 1'b0;
      end else if (w_in_xfer) begin
        w_main_n       = w_in_entry;
        w_main_valid_n = 1'b1;
      end else begin
        w_main_valid_n = 1'b0;
      end
    end else if (w_in_xfer) begin
      // main is full and stalled: park the new result in the skid register
      w_skid_n       = w_in_entry;
      w_skid_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_flag_z     <= 1'b0;
      r_flag_n     <= 1'b0;
      r_flag_c     <= 1'b0;
      r_flag_v     <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_main       <= w_main_n;
      r_skid       <= w_skid_n;
      r_main_valid <= w_main_valid_n;
      r_skid_valid <= w_skid_valid_n;
      r_in_ready   <= !w_skid_valid_n;
      // A result leaving in a flush cycle still commits.
      if (w_out_xfer) begin
        if (r_main[4]) begin
          r_flag_z <= r_main[3];
          r_flag_n <= r_main[2];
          r_flag_c <= r_main[1];
          r_flag_v <= r_main[0];
        end
        if (r_main[5]) begin
          r_cnt <= r_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_main_valid;
  assign out_y      = r_main[EW-1 -: WIDTH];
  assign out_rd     = r_main[EW-WIDTH-1 -: RADDR];
  assign out_we     = r_main[5];
  assign flag_z     = r_flag_z;
  assign flag_n     = r_flag_n;
  assign flag_c     = r_flag_c;
  assign flag_v     = r_flag_v;
  assign commit_cnt = r_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard testbench for alu_result_stage
module tb_alu_result_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_y;
  logic        in_c;
  logic        in_v;
  logic [3:0]  in_rd;
  logic        in_we;
  logic        in_setf;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic [3:0]  out_rd;
  logic        out_we;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_v;
  logic [15:0] commit_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] y;
    logic [3:0]  rd;
    logic        we;
  } exp_t;

  exp_t sb[$];

  alu_result_stage #(.WIDTH(16), .RADDR(4), .CNTW(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_c(in_c), .in_v(in_v),
    .in_rd(in_rd), .in_we(in_we), .in_setf(in_setf),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_rd(out_rd), .out_we(out_we),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .commit_cnt(commit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: sampled on the falling edge, so it sees exactly what the next
  // rising edge will act on. Pops before pushing to keep arrival order.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_output actual=%0h required=none", out_y);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_y", {16'd0, out_y}, {16'd0, e.y});
          chk("sb_rd", {28'd0, out_rd}, {28'd0, e.rd});
          chk("sb_we", {31'd0, out_we}, {31'd0, e.we});
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        sb.push_back('{y: in_y, rd: in_rd, we: in_we});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] y, input logic [3:0] rd,
                       input logic we, input logic setf, input logic c, input logic ov);
    in_valid = v;
    in_y     = y;
    in_rd    = rd;
    in_we    = we;
    in_setf  = setf;
    in_c     = c;
    in_v     = ov;
  endtask

  task automatic chk_flags(input string name, input logic [3:0] req);
    chk(name, {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, req});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_y", {16'd0, out_y}, 32'd0);
    chk("rst_out_rd_we", {27'd0, out_rd, out_we}, 32'd0);
    chk_flags("rst_flags", 4'b0000);
    chk("rst_cnt", {16'd0, commit_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single result
    out_ready = 1'b1;
    drive(1'b1, 16'h0000, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_y", {16'd0, out_y}, 32'h0);
    chk("single_rd", {28'd0, out_rd}, 32'd3);
    in_valid = 1'b0;
    tick();
    chk_flags("single_flags", 4'b1010);
    chk("single_cnt", {16'd0, commit_cnt}, 32'd1);

    // Back-to-back stream
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stream_out", {15'd0, out_valid, out_y}, {15'd0, 1'b1, 16'(i)});
    end
    in_valid = 1'b0;
    tick();
    chk("stream_cnt", {16'd0, commit_cnt}, 32'd8);

    // Stall with main and skid filling
    out_ready = 1'b0;
    drive(1'b1, 16'h8000, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("stall_ready_1", {31'd0, in_ready}, 32'd1);
    chk("stall_y_1", {16'd0, out_y}, 32'h8000);
    drive(1'b1, 16'h1234, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 16'h5555, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready_hold", {31'd0, in_ready}, 32'd0);
      chk("stall_out_hold", {11'd0, out_valid, out_y, out_rd}, {11'd0, 1'b1, 16'h8000, 4'd1});
    end
    out_ready = 1'b1;
    tick();
    chk_flags("stall_flags_8000", 4'b0101);
    chk("stall_y_2", {16'd0, out_y}, 32'h1234);
    chk("stall_ready_2", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("stall_y_3", {16'd0, out_y}, 32'h5555);
    tick();
    chk("stall_cnt", {16'd0, commit_cnt}, 32'd11);
    chk_flags("stall_flags_keep", 4'b0101);

    // setf=0 entry must not disturb flags
    drive(1'b1, 16'hFFFF, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk_flags("setf0_flags", 4'b0110);
    chk("setf0_cnt", {16'd0, commit_cnt}, 32'd13);

    // Flush with main and skid full, input offered, output ready
    out_ready = 1'b0;
    drive(1'b1, 16'h0A0A, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0B0B, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("flush_pre_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 16'h0C0C, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk_flags("flush_flags", 4'b0000);
    chk("flush_cnt", {16'd0, commit_cnt}, 32'd14);
    tick();
    tick();
    chk("flush_post_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_post_cnt", {16'd0, commit_cnt}, 32'd14);

    // Counter wrap
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, 16'(i), 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("wrap_cnt_ffff", {16'd0, commit_cnt}, 32'h0000FFFF);
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt_zero", {16'd0, commit_cnt}, 32'd0);

    // Asynchronous reset in the middle of a stall
    drive(1'b1, 16'h8000, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 16'h0001, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    chk_flags("mid_pre_flags", 4'b0111);
    chk("mid_pre_cnt", {16'd0, commit_cnt}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk_flags("mid_rst_flags", 4'b0000);
    chk("mid_rst_cnt", {16'd0, commit_cnt}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("sb_empty_end", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
